// File: rtl/dmem_rd_arbiter_if.sv
// dmem_rd_arbiter_if: requester A/B and MMU read-channel bundle.
// slave = arbiter view, master = requesters + MMU view.
interface dmem_rd_arbiter_if;
  logic        FLUSH;
  logic        A_RDEN;
  logic [31:0] A_ADDR;
  logic        A_WAIT;
  logic        A_RVALID;
  logic [31:0] A_RDATA;
  logic        B_RDEN;
  logic [31:0] B_ADDR;
  logic        B_WAIT;
  logic        B_RVALID;
  logic [31:0] B_RDATA;
  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;

  modport slave (
    input  FLUSH,
    input  A_RDEN, A_ADDR,
    output A_WAIT, A_RVALID, A_RDATA,
    input  B_RDEN, B_ADDR,
    output B_WAIT, B_RVALID, B_RDATA,
    output DATA_RDEN, DATA_RIADDR,
    input  DATA_ROADDR, DATA_RVALID, DATA_RDATA
  );

  modport master (
    output FLUSH,
    output A_RDEN, A_ADDR,
    input  A_WAIT, A_RVALID, A_RDATA,
    output B_RDEN, B_ADDR,
    input  B_WAIT, B_RVALID, B_RDATA,
    input  DATA_RDEN, DATA_RIADDR,
    output DATA_ROADDR, DATA_RVALID, DATA_RDATA
  );
endinterface

// File: rtl/dmem_rd_arbiter.sv
// dmem_rd_arbiter: two-port read arbiter onto one MMU read channel.
// Ports: CLK, RST (sync, active-high), bus (dmem_rd_arbiter_if.slave).
// One outstanding read: IDLE -> BUSY (DATA_RDEN) -> DONE (RVALID pulse).
// Define DMEM_RD_ARBITER_RR_EN for round-robin; default is A-first.
module dmem_rd_arbiter (
  input  logic             CLK,
  input  logic             RST,
  dmem_rd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d; // 0 = A, 1 = B
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        abort_q, abort_d;
  logic        rden_q, rden_d;

  logic req_a, req_b, grant_b;
  logic own_rden, match, done_ok;

  // A flush in IDLE masks port A for that cycle only.
  assign req_a = bus.A_RDEN & ~bus.FLUSH;
  assign req_b = bus.B_RDEN;

`ifdef DMEM_RD_ARBITER_RR_EN
  logic ptr_q, ptr_d; // 0 = A preferred, 1 = B preferred

  assign grant_b = req_b & (~req_a | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && (req_a | req_b))
      ptr_d = ~grant_b;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign grant_b = req_b & ~req_a;
`endif

  assign own_rden = owner_q ? bus.B_RDEN : bus.A_RDEN;
  assign match    = bus.DATA_RVALID &
                    (bus.DATA_ROADDR == addr_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          owner_d = grant_b;
          addr_d  = grant_b ? bus.B_ADDR : bus.A_ADDR;
          abort_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Abort only silences the reply; the MMU read still drains.
        if ((bus.FLUSH & ~owner_q) | ~own_rden)
          abort_d = 1'b1;
        if (match) begin
          data_d  = bus.DATA_RDATA;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rden_d = (state_d == BUSY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      rden_q  <= rden_d;
    end
  end

  assign done_ok = (state_q == DONE) & ~abort_q;

  assign bus.DATA_RDEN   = rden_q;
  assign bus.DATA_RIADDR = addr_q;
  assign bus.A_RVALID    = done_ok & ~owner_q;
  assign bus.B_RVALID    = done_ok & owner_q;
  assign bus.A_RDATA     = data_q;
  assign bus.B_RDATA     = data_q;
  assign bus.A_WAIT      = bus.A_RDEN &
                           ~(done_ok & ~owner_q);
  assign bus.B_WAIT      = bus.B_RDEN &
                           ~(done_ok & owner_q);
endmodule

// File: tb/tb_dmem_rd_arbiter.sv
// tb_dmem_rd_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_rd_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_rd_arbiter_if bus();

  dmem_rd_arbiter dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

`ifdef DMEM_RD_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic        own;
    logic [31:0] addr;
    logic        abt;
  } tx_t;

  tx_t         txq[$];
  logic        dlv, dlv_own, dlv_abt, ptr;
  logic [31:0] last_data;
  logic        e_av, e_bv;
  logic        gq[$];

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    dlv = 1'b0; dlv_own = 1'b0; dlv_abt = 1'b0;
    ptr = 1'b0;
    last_data = '0;
    e_av = 1'b0; e_bv = 1'b0;
  endtask

  task automatic quiet();
    bus.FLUSH = 1'b0;
    bus.A_RDEN = 1'b0; bus.A_ADDR = '0;
    bus.B_RDEN = 1'b0; bus.B_ADDR = '0;
    bus.DATA_RVALID = 1'b0;
    bus.DATA_ROADDR = '0;
    bus.DATA_RDATA = '0;
  endtask

  task automatic mmu(input logic v, input logic [31:0] a,
                     input logic [31:0] d);
    bus.DATA_RVALID = v;
    bus.DATA_ROADDR = a;
    bus.DATA_RDATA  = d;
  endtask

  // One cycle: check outputs against the model, advance the model
  // with this cycle's inputs, then cross the clock edge.
  task automatic tick();
    tx_t  t;
    logic a, b, g;
    #1;
    e_av = dlv & ~dlv_own & ~dlv_abt;
    e_bv = dlv & dlv_own & ~dlv_abt;
    chk1("A_RVALID", bus.A_RVALID, e_av);
    chk1("B_RVALID", bus.B_RVALID, e_bv);
    chk1("A_WAIT", bus.A_WAIT, bus.A_RDEN & ~e_av);
    chk1("B_WAIT", bus.B_WAIT, bus.B_RDEN & ~e_bv);
    chk32("A_RDATA", bus.A_RDATA, last_data);
    chk32("B_RDATA", bus.B_RDATA, last_data);
    chk1("DATA_RDEN", bus.DATA_RDEN, txq.size() == 1);
    if (txq.size() == 1)
      chk32("DATA_RIADDR", bus.DATA_RIADDR, txq[0].addr);
    if (bus.A_RVALID === 1'b1 || bus.B_RVALID === 1'b1)
      gq.push_back(bus.B_RVALID);

    if (RST) begin
      model_reset();
    end else if (dlv) begin
      dlv = 1'b0;
    end else if (txq.size() != 0) begin
      t = txq.pop_front();
      if ((bus.FLUSH && !t.own) ||
          !(t.own ? bus.B_RDEN : bus.A_RDEN))
        t.abt = 1'b1;
      if (bus.DATA_RVALID && bus.DATA_ROADDR == t.addr) begin
        last_data = bus.DATA_RDATA;
        dlv = 1'b1; dlv_own = t.own; dlv_abt = t.abt;
      end else begin
        txq.push_back(t);
      end
    end else begin
      a = bus.A_RDEN & ~bus.FLUSH;
      b = bus.B_RDEN;
      if (a || b) begin
        g = (a && b) ? (RR & ptr) : b;
        t.own  = g;
        t.addr = g ? bus.B_ADDR : bus.A_ADDR;
        t.abt  = 1'b0;
        txq.push_back(t);
        ptr = ~g;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic        a_on, b_on;
  int          budget;

  initial begin
    quiet();
    model_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk1("rst DATA_RDEN", bus.DATA_RDEN, 1'b0);
    chk32("rst DATA_RIADDR", bus.DATA_RIADDR, 32'h0);
    chk1("rst A_RVALID", bus.A_RVALID, 1'b0);
    chk1("rst B_RVALID", bus.B_RVALID, 1'b0);
    chk32("rst A_RDATA", bus.A_RDATA, 32'h0);
    chk32("rst B_RDATA", bus.B_RDATA, 32'h0);

    // single A read, MMU answers 3 cycles after DATA_RDEN
    bus.A_RDEN = 1'b1; bus.A_ADDR = 32'h100;
    tick();
    tick(); tick(); tick();
    mmu(1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("031 A_RVALID", bus.A_RVALID, 1'b1);
    chk32("031 A_RDATA", bus.A_RDATA, 32'hDEADBEEF);
    chk1("031 A_WAIT", bus.A_WAIT, 1'b0);
    chk1("031 B_RVALID", bus.B_RVALID, 1'b0);
    tick();
    bus.A_RDEN = 1'b0;
    tick();

    // both ports requesting for 4 rounds, from a fresh pointer
    RST = 1'b1; tick(); RST = 1'b0;
    gq.delete();
    bus.A_RDEN = 1'b1; bus.A_ADDR = 32'h200;
    bus.B_RDEN = 1'b1; bus.B_ADDR = 32'h300;
    budget = 0;
    while (gq.size() < 4 && budget < 40) begin
      if (txq.size() == 1) mmu(1'b1, txq[0].addr, $urandom);
      else                 mmu(1'b0, '0, '0);
      tick();
      budget++;
    end
    chk32("032 grants", gq.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk1("032 grant owner", (i < gq.size()) ? gq[i] : 1'bx,
           RR & i[0]);
    quiet();
    tick();

    // flush during A's BUSY, then B is served
    bus.A_RDEN = 1'b1; bus.A_ADDR = 32'h400;
    tick();
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    tick();
    mmu(1'b1, 32'h400, 32'h0BADF00D);
    tick();
    mmu(1'b0, '0, '0);
    bus.A_RDEN = 1'b0;
    bus.B_RDEN = 1'b1; bus.B_ADDR = 32'h500;
    #1;
    chk1("033 A_RVALID", bus.A_RVALID, 1'b0);
    tick();
    tick();
    #1;
    chk1("033 B DATA_RDEN", bus.DATA_RDEN, 1'b1);
    chk32("033 B DATA_RIADDR", bus.DATA_RIADDR, 32'h500);
    mmu(1'b1, 32'h500, 32'h55AA55AA);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("033 B_RVALID", bus.B_RVALID, 1'b1);
    chk32("033 B_RDATA", bus.B_RDATA, 32'h55AA55AA);
    tick();
    bus.B_RDEN = 1'b0;
    tick();

    // tag mismatch ignored, later match completes
    bus.A_RDEN = 1'b1; bus.A_ADDR = 32'h100;
    tick();
    mmu(1'b1, 32'h104, 32'hFFFF0000);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("034 still BUSY", bus.DATA_RDEN, 1'b1);
    chk1("034 no RVALID", bus.A_RVALID, 1'b0);
    mmu(1'b1, 32'h100, 32'h12345678);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("034 A_RVALID", bus.A_RVALID, 1'b1);
    chk32("034 A_RDATA", bus.A_RDATA, 32'h12345678);
    tick();
    bus.A_RDEN = 1'b0;
    tick();

    // reset while BUSY, stale MMU response afterwards
    bus.A_RDEN = 1'b1; bus.A_ADDR = 32'h600;
    tick();
    tick();
    RST = 1'b1; bus.A_RDEN = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    chk1("035 DATA_RDEN", bus.DATA_RDEN, 1'b0);
    chk32("035 DATA_RIADDR", bus.DATA_RIADDR, 32'h0);
    chk32("035 A_RDATA", bus.A_RDATA, 32'h0);
    tick();
    mmu(1'b1, 32'h600, 32'hCAFEF00D);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("035 A_RVALID", bus.A_RVALID, 1'b0);
    chk1("035 DATA_RDEN late", bus.DATA_RDEN, 1'b0);
    chk32("035 A_RDATA late", bus.A_RDATA, 32'h0);
    tick();

    // B drops its request mid-BUSY
    bus.B_RDEN = 1'b1; bus.B_ADDR = 32'h700;
    tick();
    tick();
    bus.B_RDEN = 1'b0;
    tick();
    #1;
    chk1("036 DATA_RDEN held", bus.DATA_RDEN, 1'b1);
    tick();
    mmu(1'b1, 32'h700, 32'h77777777);
    tick();
    mmu(1'b0, '0, '0);
    #1;
    chk1("036 B_RVALID", bus.B_RVALID, 1'b0);
    tick();
    tick();

    // random traffic
    a_on = 1'b0; b_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (a_on && e_av) a_on = 1'b0;
      if (b_on && e_bv) b_on = 1'b0;
      if (!a_on && $urandom_range(0, 2) == 0) begin
        a_on = 1'b1;
        bus.A_ADDR = 32'h100 + 32'(4 * $urandom_range(0, 3));
      end else if (a_on && $urandom_range(0, 40) == 0) begin
        a_on = 1'b0;
      end
      if (!b_on && $urandom_range(0, 2) == 0) begin
        b_on = 1'b1;
        bus.B_ADDR = 32'h100 + 32'(4 * $urandom_range(0, 3));
      end else if (b_on && $urandom_range(0, 40) == 0) begin
        b_on = 1'b0;
      end
      bus.A_RDEN = a_on;
      bus.B_RDEN = b_on;
      bus.FLUSH = ($urandom_range(0, 9) == 0);
      RST = ($urandom_range(0, 99) == 0);
      bus.DATA_RVALID = ($urandom_range(0, 2) == 0);
      if (txq.size() != 0 && $urandom_range(0, 3) != 0)
        bus.DATA_ROADDR = txq[0].addr;
      else
        bus.DATA_ROADDR = 32'h100 + 32'(4 * $urandom_range(0, 3));
      bus.DATA_RDATA = $urandom;
      tick();
    end
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
